// File: rtl/solve_ntru_mul_arbiter_if.sv
// Requester-side request/response bundle for the shared NTRU multiplier.
// Requesters drive master; the arbiter takes slave.
interface solve_ntru_mul_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*12-1:0] req_a;
    logic [NUM_REQ*8-1:0]  req_b;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [11:0]           rsp_p;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p
    );
endinterface

// File: rtl/solve_ntru_mul_arbiter.sv
// Round-robin front end for one pipelined 12s x 8ns multiplier.
// A tag pipeline shadows the multiplier so each product returns to its owner.
module solve_ntru_mul_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int MUL_LAT = 3,
    parameter int IDW     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    solve_ntru_mul_arbiter_if.slave        bus,
    output logic                           mul_ce,
    output logic [11:0]                    mul_din0,
    output logic [7:0]                     mul_din1,
    input  logic [11:0]                    mul_dout,
    output logic                           busy
);
    logic [MUL_LAT-1:0] tag_vld;
    logic [IDW-1:0]     tag_id [MUL_LAT];
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     grant_id;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rsp_vld;
    logic               found;
    logic               stall;
    logic               issue;

    always_comb begin
        rsp_vld = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_vld[i] = tag_vld[MUL_LAT-1] && !reset &&
                         (tag_id[MUL_LAT-1] == IDW'(i));
        end
    end

    // Any unaccepted result freezes the whole pipe, not just its owner.
    assign stall  = |(rsp_vld & ~bus.rsp_ready);
    assign mul_ce = ~stall;

    always_comb begin
        int idx;
        found    = 1'b0;
        grant_id = '0;
        grant    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req_valid[IDW'(idx)]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
            end
        end
        if (found && !stall && !reset) grant[grant_id] = 1'b1;
    end

    assign issue = |grant;

    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mul_din0 = bus.req_a[12*i +: 12];
                mul_din1 = bus.req_b[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld <= '0;
            rr_ptr  <= '0;
            for (int i = 0; i < MUL_LAT; i++) tag_id[i] <= '0;
        end else if (mul_ce) begin
            tag_vld[0] <= issue;
            tag_id[0]  <= grant_id;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
            if (issue) begin
                rr_ptr <= (grant_id == IDW'(NUM_REQ-1)) ? '0
                                                        : grant_id + IDW'(1);
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_vld;
    assign bus.rsp_p     = mul_dout;
    assign busy          = (|tag_vld) & ~reset;
endmodule
